// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer: state encoding and the bit positions
// of the jump-select and flag vectors supplied by the control decoder.
package microsequencer_pkg;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_HALT = 2'd2;

    // jsel = {JC, JZ, JGT, JLT}
    localparam int JSEL_W   = 4;
    localparam int JSEL_JC  = 3;
    localparam int JSEL_JZ  = 2;
    localparam int JSEL_JGT = 1;
    localparam int JSEL_JLT = 0;

    // flags = {C, Z, LT}
    localparam int FLAGS_W = 3;
    localparam int FLAG_C  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_LT = 0;

endpackage

// File: rtl/microsequencer_if.sv
// Decoder/bus side of the microsequencer. The decoder (master) drives the
// per-step control bits; the sequencer (slave) returns pc, t and status.
interface microsequencer_if
    import microsequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int T_W    = 3
);
    logic               RT;
    logic               PP;
    logic [JSEL_W-1:0]  jsel;
    logic [FLAGS_W-1:0] flags;
    logic [ADDR_W-1:0]  jaddr;
    logic               wait_req;
    logic               mem_ready;
    logic               hlt;
    logic [ADDR_W-1:0]  pc;
    logic [T_W-1:0]     t;
    logic               jmp_taken;
    logic               stalled;
    logic               halted;

    modport master (
        output RT, PP, jsel, flags, jaddr, wait_req, mem_ready, hlt,
        input  pc, t, jmp_taken, stalled, halted
    );

    modport slave (
        input  RT, PP, jsel, flags, jaddr, wait_req, mem_ready, hlt,
        output pc, t, jmp_taken, stalled, halted
    );
endinterface

// File: rtl/microsequencer_jump_cond.sv
// Combinational jump condition: selected flag tests OR-ed together, masked
// off while the sequencer is halted.
module microsequencer_jump_cond
    import microsequencer_pkg::*;
(
    input  logic               active,
    input  logic [JSEL_W-1:0]  jsel,
    input  logic [FLAGS_W-1:0] flags,
    output logic               jmp_taken
);
    logic gt;

    // GT is derived: neither equal nor less-than
    always_comb begin
        gt        = !flags[FLAG_Z] && !flags[FLAG_LT];
        jmp_taken = active && ((jsel[JSEL_JC]  && flags[FLAG_C])  ||
                               (jsel[JSEL_JZ]  && flags[FLAG_Z])  ||
                               (jsel[JSEL_JGT] && gt)             ||
                               (jsel[JSEL_JLT] && flags[FLAG_LT]));
    end
endmodule

// File: rtl/microsequencer.sv
// Fetch/execute sequencer: program counter, microstep counter and a
// RUN/WAIT/HALT state machine with memory wait states.
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                T_W      = 3,
    parameter int                T_MAX    = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               RST,
    microsequencer_if.slave    bus
);
    localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [T_W-1:0]     t_q, t_d;
    logic               stalled_q, stalled_d;
    logic               halted_q, halted_d;
    logic               active;
    logic               jmp_taken;

    assign active = (state_q != ST_HALT);

    microsequencer_jump_cond jump_cond (
        .active    (active),
        .jsel      (bus.jsel),
        .flags     (bus.flags),
        .jmp_taken (jmp_taken)
    );

    // Next state: halt beats stall, stall beats the step; jump beats PP
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        t_d     = t_q;
        if (!active) begin
            state_d = ST_HALT;
        end else if (bus.hlt) begin
            state_d = ST_HALT;
        end else if (bus.wait_req && !bus.mem_ready) begin
            state_d = ST_WAIT;
        end else begin
            state_d = ST_RUN;
            if (jmp_taken)   pc_d = bus.jaddr;
            else if (bus.PP) pc_d = pc_q + ADDR_W'(1);
            t_d = (bus.RT || t_q == T_LAST) ? '0 : t_q + T_W'(1);
        end
        stalled_d = (state_d == ST_WAIT);
        halted_d  = (state_d == ST_HALT);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            t_q       <= '0;
            stalled_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            t_q       <= t_d;
            stalled_q <= stalled_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.t         = t_q;
    assign bus.stalled   = stalled_q;
    assign bus.halted    = halted_q;
    assign bus.jmp_taken = jmp_taken;
endmodule

// File: tb/tb_microsequencer.sv
// Drives a default-parameter sequencer (A) and a narrow one (B) with the same
// control stream and checks both against an arithmetic reference model.
module tb_microsequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    microsequencer_if #(.ADDR_W(16), .T_W(3)) bus_a ();
    microsequencer_if #(.ADDR_W(8),  .T_W(2)) bus_b ();

    microsequencer #(.ADDR_W(16), .T_W(3), .T_MAX(7), .RESET_PC(16'h0000))
        dut_a (.clk(clk), .RST(rst), .bus(bus_a));
    microsequencer #(.ADDR_W(8), .T_W(2), .T_MAX(2), .RESET_PC(8'h10))
        dut_b (.clk(clk), .RST(rst), .bus(bus_b));

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, index 0 = A, 1 = B
    int m_pc[2];
    int m_t[2];
    bit m_stall[2];
    bit m_halt[2];
    bit m_valid = 1'b0;
    int aw[2]   = '{16, 8};
    int tmax[2] = '{7, 2};
    int rpc[2]  = '{0, 16};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // one clock: drive inputs, check jmp_taken, advance model, check registers
    task automatic step(input bit r, input bit rt, input bit pp, input logic [3:0] js,
                        input logic [2:0] fl, input logic [15:0] ja,
                        input bit wr, input bit mr, input bit h);
        bit cond;
        bit jt;
        rst = r;
        bus_a.RT = rt; bus_a.PP = pp; bus_a.jsel = js; bus_a.flags = fl;
        bus_a.jaddr = ja; bus_a.wait_req = wr; bus_a.mem_ready = mr; bus_a.hlt = h;
        bus_b.RT = rt; bus_b.PP = pp; bus_b.jsel = js; bus_b.flags = fl;
        bus_b.jaddr = ja[7:0]; bus_b.wait_req = wr; bus_b.mem_ready = mr; bus_b.hlt = h;
        #1;
        // flags = {C,Z,LT}; GT means neither Z nor LT
        cond = (js[3] && fl[2]) || (js[2] && fl[1]) ||
               (js[1] && !fl[1] && !fl[0]) || (js[0] && fl[0]);
        if (m_valid) begin
            chk("a.jmp_taken", 32'(bus_a.jmp_taken), 32'(!m_halt[0] && cond));
            chk("b.jmp_taken", 32'(bus_b.jmp_taken), 32'(!m_halt[1] && cond));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            jt = !m_halt[i] && cond;
            if (r) begin
                m_pc[i] = rpc[i]; m_t[i] = 0; m_stall[i] = 0; m_halt[i] = 0;
            end else if (m_halt[i]) begin
                // frozen until reset
            end else if (h) begin
                m_halt[i] = 1; m_stall[i] = 0;
            end else if (wr && !mr) begin
                m_stall[i] = 1;
            end else begin
                m_stall[i] = 0;
                if (jt)      m_pc[i] = int'(ja) % (1 << aw[i]);
                else if (pp) m_pc[i] = (m_pc[i] + 1) % (1 << aw[i]);
                m_t[i] = (rt || m_t[i] == tmax[i]) ? 0 : m_t[i] + 1;
            end
        end
        if (r) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            chk("a.pc", 32'(bus_a.pc), m_pc[0]);
            chk("a.t", 32'(bus_a.t), m_t[0]);
            chk("a.stalled", 32'(bus_a.stalled), 32'(m_stall[0]));
            chk("a.halted", 32'(bus_a.halted), 32'(m_halt[0]));
            chk("b.pc", 32'(bus_b.pc), m_pc[1]);
            chk("b.t", 32'(bus_b.t), m_t[1]);
            chk("b.stalled", 32'(bus_b.stalled), 32'(m_stall[1]));
            chk("b.halted", 32'(bus_b.halted), 32'(m_halt[1]));
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 4'h0, 3'b000, 16'h0, 0, 0, 0);
    endtask

    task automatic idle_until_t(input int tv);
        for (int k = 0; k < 16 && m_t[0] != tv; k++) idle();
    endtask

    initial begin
        // reset and free run
        step(1, 0, 0, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("rst.a.pc", 32'(bus_a.pc), 32'h0);
        chk("rst.a.t", 32'(bus_a.t), 32'h0);
        chk("rst.a.stalled", 32'(bus_a.stalled), 32'h0);
        chk("rst.a.halted", 32'(bus_a.halted), 32'h0);
        chk("rst.b.pc", 32'(bus_b.pc), 32'h10);
        for (int k = 0; k < 9; k++) begin
            idle();
            chk("run.a.t", 32'(bus_a.t), (k + 1) % 8);
            chk("run.b.t", 32'(bus_b.t), (k + 1) % 3);
            chk("run.a.pc", 32'(bus_a.pc), 32'h0);
        end

        // PC wrap at the top of the address space
        step(0, 0, 0, 4'b0100, 3'b010, 16'hFFFE, 0, 0, 0);
        step(0, 0, 1, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("wrap.a.ffff", 32'(bus_a.pc), 32'hFFFF);
        step(0, 0, 1, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("wrap.a.0000", 32'(bus_a.pc), 32'h0000);
        idle_until_t(3);
        step(0, 1, 1, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("rt.a.t", 32'(bus_a.t), 32'h0);

        // jump beats PP; JGT false when Z set
        step(0, 0, 1, 4'b0100, 3'b010, 16'h1234, 0, 0, 0);
        chk("jmp.a.pc", 32'(bus_a.pc), 32'h1234);
        step(0, 0, 1, 4'b0010, 3'b010, 16'h5555, 0, 0, 0);
        chk("nojmp.a.pc", 32'(bus_a.pc), 32'h1235);

        // wait states with a pending jump
        idle_until_t(2);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 4'b0100, 3'b010, 16'h0ABC, 1, 0, 0);
            chk("wait.a.stalled", 32'(bus_a.stalled), 32'h1);
            chk("wait.a.t", 32'(bus_a.t), 32'h2);
        end
        step(0, 0, 1, 4'b0100, 3'b010, 16'h0ABC, 1, 1, 0);
        chk("ready.a.pc", 32'(bus_a.pc), 32'h0ABC);
        chk("ready.a.t", 32'(bus_a.t), 32'h3);
        chk("ready.a.stalled", 32'(bus_a.stalled), 32'h0);

        // halt at pc=0x40, t=5
        step(0, 1, 0, 4'b0100, 3'b010, 16'h0040, 0, 0, 0);
        idle_until_t(5);
        step(0, 0, 0, 4'h0, 3'b000, 16'h0, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 1, 4'hF, 3'b111, 16'hBEEF, 0, 0, 0);
            chk("halt.a.pc", 32'(bus_a.pc), 32'h0040);
            chk("halt.a.t", 32'(bus_a.t), 32'h5);
            chk("halt.a.halted", 32'(bus_a.halted), 32'h1);
        end
        step(1, 0, 0, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("unhalt.a.halted", 32'(bus_a.halted), 32'h0);

        // hlt while stalled, then reset out of WAIT
        idle(); idle();
        step(0, 0, 1, 4'h0, 3'b000, 16'h0, 1, 0, 0);
        step(0, 0, 1, 4'h0, 3'b000, 16'h0, 1, 0, 1);
        chk("stallhalt.a.pc", 32'(bus_a.pc), 32'h0);
        chk("stallhalt.a.t", 32'(bus_a.t), 32'h2);
        step(1, 0, 0, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        step(0, 0, 0, 4'h0, 3'b000, 16'h0, 1, 0, 0);
        step(1, 0, 0, 4'h0, 3'b000, 16'h0, 1, 0, 0);
        chk("waitrst.a.stalled", 32'(bus_a.stalled), 32'h0);

        // narrow instance wraps 0xFF -> 0x00
        step(0, 0, 0, 4'b1000, 3'b100, 16'h00FF, 0, 0, 0);
        step(0, 0, 1, 4'h0, 3'b000, 16'h0, 0, 0, 0);
        chk("wrap.b.pc", 32'(bus_b.pc), 32'h00);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
